// File: rtl/motor_pkg.sv
// Shared types and default tuning constants for the steering PWM controller.
package motor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BRAKE = 2'd2
    } motor_state_t;

    localparam int DEF_POS_W     = 8;
    localparam int DEF_PWM_W     = 8;
    localparam int DEF_CENTER    = 128;
    localparam int DEF_DEADBAND  = 8;
    localparam int DEF_BASE_DUTY = 128;
    localparam int DEF_GAIN_SH   = 0;
    localparam int DEF_SPIN_TH   = 96;
    localparam int DEF_RAMP_STEP = 16;
    localparam int DEF_TIMEOUT   = 4096;

endpackage

// File: rtl/pwm_ramp_channel.sv
// One wheel: slew-limited duty/direction that only moves at the PWM wrap,
// plus the compare against the shared counter.
module pwm_ramp_channel
    import motor_pkg::*;
#(
    parameter int PWM_W     = DEF_PWM_W,
    parameter int RAMP_STEP = DEF_RAMP_STEP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrap_i,
    input  logic [PWM_W-1:0] cnt_i,
    input  logic [PWM_W-1:0] tgt_duty_i,
    input  logic             tgt_dir_i,
    output logic [PWM_W-1:0] duty_o,
    output logic             dir_o,
    output logic             pwm_o
);

    localparam logic [PWM_W-1:0] STEP = PWM_W'(RAMP_STEP);

    logic [PWM_W-1:0] duty_q, duty_d;
    logic             dir_q, dir_d;
    logic [PWM_W-1:0] gap;

    // A reversal first drains the duty to zero; the flip itself only happens
    // on a wrap where the duty is already zero, so the bridge never sees a
    // direction change under load.
    always_comb begin
        duty_d = duty_q;
        dir_d  = dir_q;
        gap    = '0;
        if (wrap_i) begin
            if (dir_q != tgt_dir_i) begin
                if (duty_q == '0) begin
                    dir_d = tgt_dir_i;
                end else if (duty_q > STEP) begin
                    duty_d = duty_q - STEP;
                end else begin
                    duty_d = '0;
                end
            end else if (tgt_duty_i > duty_q) begin
                gap    = tgt_duty_i - duty_q;
                duty_d = (gap > STEP) ? duty_q + STEP : tgt_duty_i;
            end else begin
                gap    = duty_q - tgt_duty_i;
                duty_d = (gap > STEP) ? duty_q - STEP : tgt_duty_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
            dir_q  <= 1'b1;
        end else begin
            duty_q <= duty_d;
            dir_q  <= dir_d;
        end
    end

    assign duty_o = duty_q;
    assign dir_o  = dir_q;
    assign pwm_o  = (cnt_i < duty_q);

endmodule

// File: rtl/motor_steer_pwm.sv
// Differential-drive steering: turns object position error into per-wheel
// duty/direction targets, with a watchdog and a braking state.
module motor_steer_pwm
    import motor_pkg::*;
#(
    parameter int POS_W     = DEF_POS_W,
    parameter int PWM_W     = DEF_PWM_W,
    parameter int CENTER    = DEF_CENTER,
    parameter int DEADBAND  = DEF_DEADBAND,
    parameter int BASE_DUTY = DEF_BASE_DUTY,
    parameter int GAIN_SH   = DEF_GAIN_SH,
    parameter int SPIN_TH   = DEF_SPIN_TH,
    parameter int RAMP_STEP = DEF_RAMP_STEP,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             obj_valid,
    input  logic [POS_W-1:0] obj_pos,
    output logic             pwm_left,
    output logic             pwm_right,
    output logic             dir_left,
    output logic             dir_right,
    output logic [PWM_W-1:0] duty_left,
    output logic [PWM_W-1:0] duty_right,
    output logic [1:0]       state
);

    localparam int EW   = POS_W + 1;
    localparam int DW   = POS_W + GAIN_SH + PWM_W + 2;
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);
    localparam logic [DW-1:0]   BASE_W   = DW'(BASE_DUTY);
    localparam logic [DW-1:0]   MAX_W    = DW'((1 << PWM_W) - 1);

    motor_state_t     state_q;
    logic [PWM_W-1:0] cnt_q;
    logic [WD_W-1:0]  wdog_q;
    logic [PWM_W-1:0] tgtDutyL_q, tgtDutyR_q;
    logic             tgtDirL_q, tgtDirR_q;

    logic             wrap, accept;
    logic signed [EW-1:0] err;
    logic [EW-1:0]    errMag;
    logic [DW-1:0]    delta, outerW, innerW;
    logic [PWM_W-1:0] newDutyL, newDutyR;
    logic             newDirL, newDirR;
    logic [PWM_W-1:0] effDutyL, effDutyR;
    logic             effDirL, effDirR;

    assign wrap   = (cnt_q == '1);
    assign accept = enable && obj_valid && (state_q == ST_IDLE || state_q == ST_RUN);

    assign err    = $signed({1'b0, obj_pos}) - $signed(EW'(CENTER));
    assign errMag = err[EW-1] ? EW'(-err) : EW'(err);
    assign delta  = DW'(errMag) << GAIN_SH;
    assign outerW = (BASE_W + delta > MAX_W) ? MAX_W : BASE_W + delta;
    assign innerW = (delta >= BASE_W) ? '0 : BASE_W - delta;

    // Negative error means the object is to the left, so the left wheel is
    // the inner one; past the spin threshold the inner wheel reverses.
    always_comb begin
        newDutyL = PWM_W'(BASE_DUTY);
        newDutyR = PWM_W'(BASE_DUTY);
        newDirL  = 1'b1;
        newDirR  = 1'b1;
        if (errMag > EW'(DEADBAND)) begin
            if (err[EW-1]) begin
                newDutyR = PWM_W'(outerW);
                if (errMag > EW'(SPIN_TH)) begin
                    newDirL = 1'b0;
                end else begin
                    newDutyL = PWM_W'(innerW);
                end
            end else begin
                newDutyL = PWM_W'(outerW);
                if (errMag > EW'(SPIN_TH)) begin
                    newDirR = 1'b0;
                end else begin
                    newDutyR = PWM_W'(innerW);
                end
            end
        end
    end

    // Braking holds each wheel's present direction so it only ramps down.
    always_comb begin
        effDutyL = '0;
        effDutyR = '0;
        effDirL  = 1'b1;
        effDirR  = 1'b1;
        case (state_q)
            ST_RUN: begin
                effDutyL = tgtDutyL_q;
                effDutyR = tgtDutyR_q;
                effDirL  = tgtDirL_q;
                effDirR  = tgtDirR_q;
            end
            ST_BRAKE: begin
                effDirL = dir_left;
                effDirR = dir_right;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PWM_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wdog_q     <= '0;
            tgtDutyL_q <= '0;
            tgtDutyR_q <= '0;
            tgtDirL_q  <= 1'b1;
            tgtDirR_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wdog_q <= '0;
                    if (accept) begin
                        state_q    <= ST_RUN;
                        tgtDutyL_q <= newDutyL;
                        tgtDutyR_q <= newDutyR;
                        tgtDirL_q  <= newDirL;
                        tgtDirR_q  <= newDirR;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        wdog_q     <= '0;
                        tgtDutyL_q <= newDutyL;
                        tgtDutyR_q <= newDutyR;
                        tgtDirL_q  <= newDirL;
                        tgtDirR_q  <= newDirR;
                    end else if (!enable || wdog_q == WD_LIMIT) begin
                        state_q    <= ST_BRAKE;
                        wdog_q     <= '0;
                        tgtDutyL_q <= '0;
                        tgtDutyR_q <= '0;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
                ST_BRAKE: begin
                    wdog_q <= '0;
                    if (duty_left == '0 && duty_right == '0) begin
                        state_q   <= ST_IDLE;
                        tgtDirL_q <= 1'b1;
                        tgtDirR_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    wdog_q  <= '0;
                end
            endcase
        end
    end

    pwm_ramp_channel #(.PWM_W(PWM_W), .RAMP_STEP(RAMP_STEP)) u_left (
        .clk        (clk),
        .rst_n      (rst_n),
        .wrap_i     (wrap),
        .cnt_i      (cnt_q),
        .tgt_duty_i (effDutyL),
        .tgt_dir_i  (effDirL),
        .duty_o     (duty_left),
        .dir_o      (dir_left),
        .pwm_o      (pwm_left)
    );

    pwm_ramp_channel #(.PWM_W(PWM_W), .RAMP_STEP(RAMP_STEP)) u_right (
        .clk        (clk),
        .rst_n      (rst_n),
        .wrap_i     (wrap),
        .cnt_i      (cnt_q),
        .tgt_duty_i (effDutyR),
        .tgt_dir_i  (effDirR),
        .duty_o     (duty_right),
        .dir_o      (dir_right),
        .pwm_o      (pwm_right)
    );

    assign state = state_q;

endmodule

// File: tb/tb_motor_steer_pwm.sv
// Directed-vector bench for motor_steer_pwm at default parameters.
module tb_motor_steer_pwm;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       obj_valid;
    logic [7:0] obj_pos;
    logic       pwm_left, pwm_right, dir_left, dir_right;
    logic [7:0] duty_left, duty_right;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] pos;
        int         wraps;
        int         dutyL;
        logic       dirL;
        int         dutyR;
        logic       dirR;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[15];

    motor_steer_pwm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .obj_valid  (obj_valid),
        .obj_pos    (obj_pos),
        .pwm_left   (pwm_left),
        .pwm_right  (pwm_right),
        .dir_left   (dir_left),
        .dir_right  (dir_right),
        .duty_left  (duty_left),
        .duty_right (duty_right),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench copy of the free-running PWM counter, used only to find wraps.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic valid, input logic [7:0] pos);
        enable    = en;
        obj_valid = valid;
        obj_pos   = pos;
        @(posedge clk);
        @(negedge clk);
        obj_valid = 1'b0;
    endtask

    task automatic waitWraps(input int n);
        int guard;
        for (int k = 0; k < n; k++) begin
            guard = 0;
            do begin
                @(posedge clk);
                #1;
                guard++;
            end while ((cyc % 256) != 0 && guard < 300);
            if (guard >= 300) begin
                $display("[TB] FAIL wrap_wait: got %0d cycles expected at most 256", guard);
                $fatal(1, "[TB] no counter wrap");
            end
        end
        @(negedge clk);
    endtask

    task automatic checkAll(input string tag, input int dL, input int drL,
                            input int dR, input int drR, input int st);
        checkOutput({tag, " duty_left"},  int'(duty_left),  dL);
        checkOutput({tag, " dir_left"},   int'(dir_left),   drL);
        checkOutput({tag, " duty_right"}, int'(duty_right), dR);
        checkOutput({tag, " dir_right"},  int'(dir_right),  drR);
        checkOutput({tag, " state"},      int'(state),      st);
    endtask

    initial begin
        int highL, highR;

        vecs[0]  = '{8'd128, 1, 16,  1'b1, 16,  1'b1, 2'd1};
        vecs[1]  = '{8'd128, 7, 128, 1'b1, 128, 1'b1, 2'd1};
        vecs[2]  = '{8'd50,  1, 112, 1'b1, 144, 1'b1, 2'd1};
        vecs[3]  = '{8'd50,  3, 64,  1'b1, 192, 1'b1, 2'd1};
        vecs[4]  = '{8'd50,  1, 50,  1'b1, 206, 1'b1, 2'd1};
        vecs[5]  = '{8'd128, 5, 128, 1'b1, 128, 1'b1, 2'd1};
        vecs[6]  = '{8'd250, 1, 144, 1'b1, 112, 1'b1, 2'd1};
        vecs[7]  = '{8'd250, 6, 240, 1'b1, 16,  1'b1, 2'd1};
        vecs[8]  = '{8'd250, 1, 250, 1'b1, 0,   1'b1, 2'd1};
        vecs[9]  = '{8'd250, 1, 250, 1'b1, 0,   1'b0, 2'd1};
        vecs[10] = '{8'd250, 1, 250, 1'b1, 16,  1'b0, 2'd1};
        vecs[11] = '{8'd250, 7, 250, 1'b1, 128, 1'b0, 2'd1};
        vecs[12] = '{8'd128, 1, 234, 1'b1, 112, 1'b0, 2'd1};
        vecs[13] = '{8'd128, 8, 128, 1'b1, 0,   1'b1, 2'd1};
        vecs[14] = '{8'd128, 8, 128, 1'b1, 128, 1'b1, 2'd1};

        rst_n     = 1'b0;
        enable    = 1'b0;
        obj_valid = 1'b0;
        obj_pos   = 8'd0;
        repeat (3) @(negedge clk);
        checkAll("reset", 0, 1, 0, 1, 0);
        checkOutput("reset pwm_left",  int'(pwm_left),  0);
        checkOutput("reset pwm_right", int'(pwm_right), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, 1'b1, vecs[i].pos);
            waitWraps(vecs[i].wraps);
            checkAll($sformatf("vec%0d", i), vecs[i].dutyL, int'(vecs[i].dirL),
                     vecs[i].dutyR, int'(vecs[i].dirR), int'(vecs[i].st));
            if (i == 1) begin
                highL = 0;
                highR = 0;
                for (int c = 0; c < 256; c++) begin
                    if (pwm_left)  highL++;
                    if (pwm_right) highR++;
                    @(negedge clk);
                end
                checkOutput("cruise pwm_left high cycles",  highL, 128);
                checkOutput("cruise pwm_right high cycles", highR, 128);
            end
        end

        // Watchdog: last strobe was one cycle after the previous wrap, so the
        // 16th wrap is still in RUN and the 17th is the first braking wrap.
        waitWraps(8);
        checkAll("wdog wrap16", 128, 1, 128, 1, 1);
        waitWraps(1);
        checkAll("brake wrap1", 112, 1, 112, 1, 2);
        applyStimulus(1'b1, 1'b1, 8'd250);
        checkOutput("brake ignores strobe state", int'(state), 2);
        waitWraps(1);
        checkAll("brake wrap2", 96, 1, 96, 1, 2);
        waitWraps(6);
        checkAll("brake drained", 0, 1, 0, 1, 2);
        @(negedge clk);
        checkOutput("brake to idle state", int'(state), 0);

        applyStimulus(1'b0, 1'b1, 8'd128);
        checkOutput("disabled strobe stays idle", int'(state), 0);
        applyStimulus(1'b1, 1'b1, 8'd128);
        checkOutput("enabled strobe to run", int'(state), 1);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("enable low to brake", int'(state), 2);
        @(negedge clk);
        checkOutput("zero duty brake to idle", int'(state), 0);

        applyStimulus(1'b1, 1'b1, 8'd128);
        waitWraps(6);
        checkAll("pre-reset ramp", 96, 1, 96, 1, 1);
        checkOutput("pre-reset pwm_left", int'(pwm_left), 1);
        #2 rst_n = 1'b0;
        #1;
        checkAll("async reset", 0, 1, 0, 1, 0);
        checkOutput("async reset pwm_left",  int'(pwm_left),  0);
        checkOutput("async reset pwm_right", int'(pwm_right), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
